// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared definitions for the 8-bit CPU family program memory.
//   - opcode constants used to build program images
//   - the default boot program (LDA_IMM AA, STA_DIR E0, BRA 00)
//   - checksum scan FSM state encoding
// No ports; imported with "import cpu8_pkg::*;".
package cpu8_pkg;

  // Opcode map
  localparam logic [7:0] LDA_IMM = 8'h10;
  localparam logic [7:0] LDA_DIR = 8'h11;
  localparam logic [7:0] LDB_IMM = 8'h12;
  localparam logic [7:0] LDB_DIR = 8'h13;
  localparam logic [7:0] STA_DIR = 8'h14;
  localparam logic [7:0] STB_DIR = 8'h15;
  localparam logic [7:0] ADD_AB  = 8'h20;
  localparam logic [7:0] SUB_AB  = 8'h21;
  localparam logic [7:0] AND_AB  = 8'h22;
  localparam logic [7:0] OR_AB   = 8'h23;
  localparam logic [7:0] INCA    = 8'h24;
  localparam logic [7:0] INCB    = 8'h25;
  localparam logic [7:0] DECA    = 8'h26;
  localparam logic [7:0] DECB    = 8'h27;
  localparam logic [7:0] BRA     = 8'h30;
  localparam logic [7:0] BMI     = 8'h31;
  localparam logic [7:0] BPL     = 8'h32;
  localparam logic [7:0] BEQ     = 8'h33;
  localparam logic [7:0] BNE     = 8'h34;
  localparam logic [7:0] BVS     = 8'h35;
  localparam logic [7:0] BVC     = 8'h36;
  localparam logic [7:0] BCS     = 8'h37;
  localparam logic [7:0] BCD     = 8'h38;

  // Default program: load A with AA, store it to E0, loop forever.
  localparam int DEFAULT_PROG_LEN = 6;
  localparam logic [7:0] DEFAULT_PROG [DEFAULT_PROG_LEN] =
    '{LDA_IMM, 8'hAA, STA_DIR, 8'hE0, BRA, 8'h00};

  // Checksum scan FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl: checksum scan engine for rom_sync_param.
// Walks every ROM word once, one word per cycle, and sums them modulo
// 2^DATA_WIDTH.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   chk_start      start request, honoured only in IDLE
//   scan_word      ROM word at scan_idx (supplied by the storage owner)
//   scan_idx       index of the word being summed this cycle
//   chk_busy       high for exactly DEPTH cycles while summing
//   chk_done       one-cycle pulse carrying the final sum
//   chk_sum        last completed sum; held until next completion or reset
//   state          FSM state, exported for arbitration and debug
module rom_scan_ctrl
  import cpu8_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int IDX_W      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chk_start,
  input  logic [DATA_WIDTH-1:0] scan_word,
  output logic [IDX_W-1:0]      scan_idx,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic [DATA_WIDTH-1:0] chk_sum,
  output scan_state_t           state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  scan_state_t           state_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic [DATA_WIDTH-1:0] acc_q, acc_n;
  logic [DATA_WIDTH-1:0] sum_q, sum_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      state <= state_n;
      idx_q <= idx_n;
      acc_q <= acc_n;
      sum_q <= sum_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx_q;
    acc_n   = acc_q;
    sum_n   = sum_q;
    case (state)
      IDLE: begin
        if (chk_start) begin
          state_n = SCAN;
          idx_n   = '0;
          acc_n   = '0;
        end
      end
      SCAN: begin
        acc_n = acc_q + scan_word;
        idx_n = idx_q + 1'b1;
        // Publish the sum on the same edge that enters DONE so chk_sum is
        // already final while chk_done is high.
        if (idx_q == LAST_IDX) begin
          state_n = DONE;
          sum_n   = acc_q + scan_word;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign scan_idx = idx_q;
  assign chk_busy = (state == SCAN);
  assign chk_done = (state == DONE);
  assign chk_sum  = sum_q;

endmodule

// File: rtl/rom_sync_param.sv
// rom_sync_param: parametrised synchronous program ROM with read-valid
// handshake, out-of-range flag and built-in checksum scanner.
// Handshake: a read is accepted on a rising edge when rd_en=1, the address
// is below DEPTH and no scan is running; the result is presented with
// data_valid=1 for one cycle (latency 1, or 2 with ROM_OUT_REG_EN). A read
// with address >= DEPTH outside a scan produces a one-cycle addr_err in the
// same slot instead, and data_out keeps its previous value. Reads during a
// scan are dropped silently.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rd_en, address      read request and address
//   data_out            read data (holds between reads)
//   data_valid          data_out carries a freshly accepted read
//   addr_err            a read was rejected for address >= DEPTH
//   chk_start           request a checksum scan
//   chk_busy, chk_done  scan in progress / one-cycle completion pulse
//   chk_sum             modulo-2^DATA_WIDTH sum of all DEPTH words
// Build option: define ROM_OUT_REG_EN to add an output register stage
// (read latency 2; data_valid and addr_err delayed to stay aligned).
// INIT_FILE: empty selects the default program from cpu8_pkg. A non-empty
// name leaves the array zero-filled here; the image is expected to be
// applied by the memory-initialisation step of the implementation flow.
module rom_sync_param
  import cpu8_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 8,
  parameter int    DEPTH      = 128,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  addr_err,
  input  logic                  chk_start,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic [DATA_WIDTH-1:0] chk_sum
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef logic [DATA_WIDTH-1:0] rom_t [DEPTH];

  function automatic rom_t build_rom();
    rom_t r;
    for (int i = 0; i < DEPTH; i++) r[i] = '0;
    if (INIT_FILE == "") begin
      for (int i = 0; i < DEFAULT_PROG_LEN && i < DEPTH; i++)
        r[i] = DATA_WIDTH'(DEFAULT_PROG[i]);
    end
    return r;
  endfunction

  localparam rom_t ROM = build_rom();

  scan_state_t           scan_state;
  logic [IDX_W-1:0]      scan_idx;
  logic [DATA_WIDTH-1:0] scan_word;

  logic                  in_range;
  logic                  rd_ok;
  logic                  rd_bad;
  logic [DATA_WIDTH-1:0] d1_q;
  logic                  v1_q;
  logic                  e1_q;

  // Full-width compare: no truncation or wrap of the address.
  assign in_range = ({1'b0, address} < DEPTH_W);
  assign rd_ok    = rd_en && (scan_state != SCAN) && in_range;
  assign rd_bad   = rd_en && (scan_state != SCAN) && !in_range;

  assign scan_word = ROM[scan_idx];

  rom_scan_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .chk_start (chk_start),
    .scan_word (scan_word),
    .scan_idx  (scan_idx),
    .chk_busy  (chk_busy),
    .chk_done  (chk_done),
    .chk_sum   (chk_sum),
    .state     (scan_state)
  );

  // First read stage. The index slice is safe: it is only used when
  // in_range guarantees the upper address bits are zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      d1_q <= '0;
      v1_q <= 1'b0;
      e1_q <= 1'b0;
    end else begin
      v1_q <= rd_ok;
      e1_q <= rd_bad;
      if (rd_ok) d1_q <= ROM[address[IDX_W-1:0]];
    end
  end

`ifdef ROM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] d2_q;
  logic                  v2_q;
  logic                  e2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      d2_q <= '0;
      v2_q <= 1'b0;
      e2_q <= 1'b0;
    end else begin
      d2_q <= d1_q;
      v2_q <= v1_q;
      e2_q <= e1_q;
    end
  end

  assign data_out   = d2_q;
  assign data_valid = v2_q;
  assign addr_err   = e2_q;
`else
  assign data_out   = d1_q;
  assign data_valid = v1_q;
  assign addr_err   = e1_q;
`endif

endmodule

// File: tb/tb_rom_sync_param.sv
// Bench for rom_sync_param (default parameters, 128x8, default program).
module tb_rom_sync_param;

  localparam int DEPTH = 128;
`ifdef ROM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  // clock / reset / DUT signals
  logic       clk = 1'b0;
  logic       reset;
  logic       rd_en;
  logic [7:0] address;
  logic [7:0] data_out;
  logic       data_valid;
  logic       addr_err;
  logic       chk_start;
  logic       chk_busy;
  logic       chk_done;
  logic [7:0] chk_sum;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [7:0]  last_data = 8'h00;
  logic [7:0]  prog [6] = '{8'h10, 8'hAA, 8'h14, 8'hE0, 8'h30, 8'h00};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_sync_param dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .address    (address),
    .data_out   (data_out),
    .data_valid (data_valid),
    .addr_err   (addr_err),
    .chk_start  (chk_start),
    .chk_busy   (chk_busy),
    .chk_done   (chk_done),
    .chk_sum    (chk_sum)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] rom_model(input logic [7:0] a);
    if (a < 8'd6) return prog[a];
    return 8'h00;
  endfunction

  // driver: issue one read in the current cycle, record the expected response
  task automatic rd(input logic [7:0] a);
    exp_t e;
    rd_en   = 1'b1;
    address = a;
    e.cyc   = cyc + LAT;
    if (a < 8'h80) begin
      e.err     = 1'b0;
      e.data    = rom_model(a);
      last_data = e.data;
    end else begin
      e.err  = 1'b1;
      e.data = last_data;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (data_valid || addr_err)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: valid=%0b err=%0b data=%0h, required no output (cycle %0d)",
                 data_valid, addr_err, data_out, cyc);
      end else begin
        e = exp_q.pop_front();
        check("out_kind", {30'd0, data_valid, addr_err}, e.err ? 32'd1 : 32'd2);
        check("out_data", {24'd0, data_out}, {24'd0, e.data});
        check("out_cycle", cyc, e.cyc);
      end
    end
  end

  // One checksum scan started at the current negedge. abort_n >= 0 asserts
  // reset that many cycles into the scan.
  task automatic do_scan(input int abort_n, input logic with_read,
                         input logic [7:0] prev_sum);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_n   = -1;
    chk_start = 1'b1;
    if (with_read) rd(8'h02);
    else @(negedge clk);
    chk_start = 1'b0;
    rd_en     = 1'b0;
    for (int n = 0; n < DEPTH + 8; n++) begin
      if (abort_n >= 0 && n == abort_n + 1) begin
        check("abort_busy", {31'd0, chk_busy}, 32'd0);
        check("abort_sum", {24'd0, chk_sum}, 32'd0);
      end
      if (n == 1) check("sum_held_at_start", {24'd0, chk_sum}, {24'd0, prev_sum});
      if (chk_busy) busy_cnt++;
      if (chk_done) begin
        done_cnt++;
        done_n = n;
        check("scan_sum", {24'd0, chk_sum}, 32'hDE);
      end
      rd_en     = (n == 10);
      address   = 8'h01;
      chk_start = (n == 20);
      reset     = (abort_n >= 0 && n == abort_n);
      if (reset) begin
        exp_q.delete();
        last_data = 8'h00;
      end
      @(negedge clk);
    end
    reset = 1'b0; rd_en = 1'b0; chk_start = 1'b0;
    if (abort_n >= 0) begin
      check("abort_no_done", done_cnt, 0);
    end else begin
      check("busy_cycles", busy_cnt, DEPTH);
      check("done_pulses", done_cnt, 1);
      check("done_timing", done_n, DEPTH);
      check("sum_holds", {24'd0, chk_sum}, 32'hDE);
    end
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0; address = 8'h00; chk_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_err", {31'd0, addr_err}, 32'd0);
    check("rst_busy", {31'd0, chk_busy}, 32'd0);
    check("rst_done", {31'd0, chk_done}, 32'd0);
    check("rst_sum", {24'd0, chk_sum}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // back-to-back reads of the default program
    for (int a = 0; a < 6; a++) rd(8'(a));
    rd_en = 1'b0;
    repeat (4) @(negedge clk);

    // range boundaries mixed with valid reads
    rd(8'h03); rd(8'h80); rd(8'h01); rd(8'hFF); rd(8'h7F); rd(8'h00);
    rd_en = 1'b0;
    repeat (4) @(negedge clk);

    // scan with a same-edge read, a blocked read and an ignored restart
    do_scan(-1, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    // reset 50 cycles into a scan, then a clean scan
    do_scan(50, 1'b0, 8'hDE);
    repeat (3) @(negedge clk);
    do_scan(-1, 1'b0, 8'h00);

    rd(8'h01); rd(8'h80);
    rd_en = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_sync_param.md
Name: rom_sync_param

Overview:
- Parametrised synchronous program ROM for the 8-bit CPU family; generalises the fixed 128x8 ROM in width, depth and initial contents.
- Adds a read-valid handshake and an out-of-range error flag.
- Adds a built-in checksum scanner that sums every word so boot/test logic can verify ROM integrity.
- Sits between the CPU control unit's address bus and the data-in mux, in the program-memory region.

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 8, width of the address bus.
- DEPTH, 128, number of words; legal range 2..2**ADDR_WIDTH.
- INIT_FILE, "", hex file loaded at elaboration. If empty, the default program is used: LDA_IMM AA, STA_DIR E0, BRA 00. All other words are 0.

Ports:
- clk  in  1  single clock, all logic on the rising edge
- reset  in  1  synchronous, active-high
- rd_en  in  1  read request, sampled on the rising edge
- address  in  ADDR_WIDTH  read address
- data_out  out  DATA_WIDTH  read data
- data_valid  out  1  data_out updated by the read accepted last cycle
- addr_err  out  1  read rejected because address >= DEPTH
- chk_start  in  1  request a checksum scan
- chk_busy  out  1  scan in progress
- chk_done  out  1  one-cycle pulse when the scan completes
- chk_sum  out  DATA_WIDTH  modulo-2^DATA_WIDTH sum of all DEPTH words

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on port reset.
- Reset values: data_out=0, data_valid=0, addr_err=0, chk_busy=0, chk_done=0, chk_sum=0, FSM in IDLE. Reset does not alter ROM contents.
- Read, latency 1:
  - rd_en=1, address<DEPTH, chk_busy=0 at edge T -> data_out=ROM[address] and data_valid=1 at T+1.
  - Otherwise data_valid=0 at T+1 and data_out holds its last value.
- Address out of range: rd_en=1 with address>=DEPTH at T -> addr_err=1 for one cycle at T+1, data_valid=0, data_out unchanged. addr_err is 0 in every other cycle.
- Address indexing uses the full address; there is no truncation or wrap. With DEPTH=2**ADDR_WIDTH, addr_err never asserts.
- Back-to-back reads: one accepted read per cycle, no bubbles.
- Scan FSM states and transitions:
  - IDLE -> SCAN when chk_start=1 at edge T. Index and accumulator clear to 0.
  - SCAN: chk_busy=1 for cycles T+1..T+DEPTH. One word is added per cycle; the accumulator wraps mod 2^DATA_WIDTH.
  - DONE: at T+DEPTH+1, chk_done=1 for that one cycle, chk_busy=0, chk_sum = final sum, then return to IDLE.
  - chk_sum holds until the next completed scan or reset; it is not cleared at scan start.
- During SCAN, rd_en is not accepted: data_valid=0 and addr_err=0.
- chk_start while chk_busy=1 is ignored.
- chk_start and rd_en both asserted in IDLE at the same edge: the read is served normally at T+1, and the scan begins that same cycle.
- Reset mid-scan aborts the scan: IDLE, chk_sum=0, no chk_done pulse.

Optional Feature:
- Macro: ROM_OUT_REG_EN.
- Defined: adds an output register stage. Read latency becomes 2; data_valid and addr_err are delayed one cycle to stay aligned with data_out. The second stage resets to 0. Scan timing is unchanged.
- Undefined: latency 1 as specified above.

Decomposition:
- Package cpu8_pkg holds:
  - opcode constants (LDA_IMM=8'h10 ... BCD=8'h38);
  - default program words;
  - scan state enum (IDLE, SCAN, DONE).
- Natural sub-module: rom_scan_ctrl, containing the scan FSM, index counter, accumulator and busy/done generation. The top level holds the storage array, the read port and the arbitration between scan and CPU reads.

Test Plan:
- Reset, then rd_en=1 at addresses 0,1,2,3,4,5 back-to-back -> data_out = 10,AA,14,E0,30,00 in successive cycles with data_valid=1 throughout; data_valid=0 after rd_en drops.
- rd_en=1, address=8'h80 (DEPTH=128) -> one-cycle addr_err=1, data_valid=0, data_out unchanged; next read at 8'h01 -> AA, addr_err=0.
- chk_start pulse with the default program -> chk_busy high for exactly 128 cycles; chk_done pulses once; chk_sum=8'hDE and holds afterwards.
- rd_en=1 at address 1 during SCAN -> data_valid=0 and no addr_err. A second chk_start mid-scan has no effect; done timing is unchanged.
- Reset asserted 50 cycles into a scan -> chk_busy=0 and chk_sum=0 next cycle, no chk_done. A new scan then completes with 8'hDE.
- With ROM_OUT_REG_EN, read at address 1 -> AA with data_valid=1 two cycles after the request. Out-of-range read -> addr_err two cycles later.
